// File: rtl/cache_mem_arbiter_pkg.sv
// Shared types for the I/D-cache burst memory arbiter.
package arb_types;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_DATA,
        WR_DATA,
        RESP
    } arb_state_t;

    typedef enum logic {
        REQ_I,
        REQ_D
    } req_id_t;

    localparam int unsigned DEF_LINE_W  = 256;
    localparam int unsigned DEF_BURST_W = 64;
    localparam int unsigned BEAT_CNT_W  = $clog2(DEF_LINE_W / DEF_BURST_W);

endpackage

// File: rtl/cache_mem_arbiter_line_burst_buf.sv
// Line register: loads a whole line or one beat at a time, and presents any beat for serialisation.
module line_burst_buf
    import arb_types::*;
#(
    parameter int unsigned LINE_W  = DEF_LINE_W,
    parameter int unsigned BURST_W = DEF_BURST_W,
    parameter int unsigned CNT_W   = BEAT_CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_line_i,
    input  logic [LINE_W-1:0]  line_i,
    input  logic               load_beat_i,
    input  logic [CNT_W-1:0]   beat_idx_i,
    input  logic [BURST_W-1:0] beat_i,
    output logic [LINE_W-1:0]  line_o,
    output logic [BURST_W-1:0] beat_o
);

    logic [LINE_W-1:0] line_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            line_q <= '0;
        end else if (load_line_i) begin
            line_q <= line_i;
        end else if (load_beat_i) begin
            line_q[beat_idx_i*BURST_W +: BURST_W] <= beat_i;
        end
    end

    assign line_o = line_q;
    assign beat_o = line_q[beat_idx_i*BURST_W +: BURST_W];

endmodule

// File: rtl/cache_mem_arbiter.sv
// Arbitrates the I-cache and D-cache line ports onto one burst memory port.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-break; otherwise the D-cache wins ties.
module cache_mem_arbiter
    import arb_types::*;
#(
    parameter int unsigned LINE_W  = DEF_LINE_W,
    parameter int unsigned BURST_W = DEF_BURST_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        i_addr,
    input  logic               i_read,
    output logic [LINE_W-1:0]  i_rdata,
    output logic               i_resp,
    input  logic [31:0]        d_addr,
    input  logic               d_read,
    input  logic               d_write,
    input  logic [LINE_W-1:0]  d_wdata,
    output logic [LINE_W-1:0]  d_rdata,
    output logic               d_resp,
    output logic [31:0]        bmem_addr,
    output logic               bmem_read,
    output logic               bmem_write,
    output logic [BURST_W-1:0] bmem_wdata,
    input  logic               bmem_ready,
    input  logic [BURST_W-1:0] bmem_rdata,
    input  logic               bmem_rvalid
);

    localparam int unsigned BEATS     = LINE_W / BURST_W;
    localparam int unsigned CNT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned OFF_W     = $clog2(LINE_W / 8);
    localparam logic [31:0] ADDR_MASK = ~((32'd1 << OFF_W) - 32'd1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    arb_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    req_id_t           grant_q, grant_d;
    logic [31:0]       addr_q, addr_d;
    req_id_t           pick, tie_pick;
    logic              any_req;
    logic              buf_load_line, buf_load_beat;
    logic [LINE_W-1:0] buf_line;
    logic [BURST_W-1:0] buf_beat;

`ifdef ARB_ROUND_ROBIN_EN
    req_id_t last_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= REQ_I;
        end else if (state_q == IDLE && any_req) begin
            last_q <= pick;
        end
    end

    assign tie_pick = (last_q == REQ_I) ? REQ_D : REQ_I;
`else
    assign tie_pick = REQ_D;
`endif

    assign any_req = i_read || d_read || d_write;

    always_comb begin
        if (i_read && (d_read || d_write)) begin
            pick = tie_pick;
        end else if (d_read || d_write) begin
            pick = REQ_D;
        end else begin
            pick = REQ_I;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            grant_q <= REQ_I;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        grant_d       = grant_q;
        addr_d        = addr_q;
        buf_load_line = 1'b0;
        buf_load_beat = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant_d = pick;
                    addr_d  = ((pick == REQ_D) ? d_addr : i_addr) & ADDR_MASK;
                    cnt_d   = '0;
                    // A simultaneous d_read is ignored when d_write is high.
                    if (pick == REQ_D && d_write) begin
                        buf_load_line = 1'b1;
                        state_d       = WR_DATA;
                    end else begin
                        state_d = RD_REQ;
                    end
                end
            end
            RD_REQ: begin
                if (bmem_ready) begin
                    state_d = RD_DATA;
                end
            end
            RD_DATA: begin
                if (bmem_rvalid) begin
                    buf_load_beat = 1'b1;
                    if (cnt_q == LAST_BEAT) begin
                        cnt_d   = '0;
                        state_d = RESP;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            WR_DATA: begin
                if (bmem_ready) begin
                    if (cnt_q == LAST_BEAT) begin
                        cnt_d   = '0;
                        state_d = RESP;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    line_burst_buf #(
        .LINE_W  (LINE_W),
        .BURST_W (BURST_W),
        .CNT_W   (CNT_W)
    ) u_buf (
        .clk         (clk),
        .rst         (rst),
        .load_line_i (buf_load_line),
        .line_i      (d_wdata),
        .load_beat_i (buf_load_beat),
        .beat_idx_i  (cnt_q),
        .beat_i      (bmem_rdata),
        .line_o      (buf_line),
        .beat_o      (buf_beat)
    );

    assign bmem_addr  = addr_q;
    assign bmem_read  = (state_q == RD_REQ);
    assign bmem_write = (state_q == WR_DATA);
    assign bmem_wdata = (state_q == WR_DATA) ? buf_beat : '0;
    assign i_resp     = (state_q == RESP) && (grant_q == REQ_I);
    assign d_resp     = (state_q == RESP) && (grant_q == REQ_D);
    assign i_rdata    = i_resp ? buf_line : '0;
    assign d_rdata    = d_resp ? buf_line : '0;

    a_d_rw_exclusive: assert property (@(posedge clk) disable iff (rst)
        !(d_read && d_write));

    a_i_req_held: assert property (@(posedge clk) disable iff (rst)
        (state_q != IDLE && grant_q == REQ_I) |-> i_read);

    a_d_req_held: assert property (@(posedge clk) disable iff (rst)
        (state_q != IDLE && grant_q == REQ_D) |-> (d_read || d_write));

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: vector table plus reset, tie and stray-beat sequences.
module tb_cache_mem_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  i_addr;
    logic         i_read;
    logic [255:0] i_rdata;
    logic         i_resp;
    logic [31:0]  d_addr;
    logic         d_read;
    logic         d_write;
    logic [255:0] d_wdata;
    logic [255:0] d_rdata;
    logic         d_resp;
    logic [31:0]  bmem_addr;
    logic         bmem_read;
    logic         bmem_write;
    logic [63:0]  bmem_wdata;
    logic         bmem_ready;
    logic [63:0]  bmem_rdata;
    logic         bmem_rvalid;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cache_mem_arbiter #(
        .LINE_W  (256),
        .BURST_W (64)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_addr      (i_addr),
        .i_read      (i_read),
        .i_rdata     (i_rdata),
        .i_resp      (i_resp),
        .d_addr      (d_addr),
        .d_read      (d_read),
        .d_write     (d_write),
        .d_wdata     (d_wdata),
        .d_rdata     (d_rdata),
        .d_resp      (d_resp),
        .bmem_addr   (bmem_addr),
        .bmem_read   (bmem_read),
        .bmem_write  (bmem_write),
        .bmem_wdata  (bmem_wdata),
        .bmem_ready  (bmem_ready),
        .bmem_rdata  (bmem_rdata),
        .bmem_rvalid (bmem_rvalid)
    );

    typedef struct {
        bit           is_i;
        bit           wr;
        logic [31:0]  addr;
        logic [31:0]  exp_addr;
        logic [255:0] line;
        int unsigned  stall_beat;
        int unsigned  stall_n;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Request must already be raised; drops it one cycle after the response.
    task automatic serve_read(input bit is_i, input logic [31:0] exp_addr,
                              input logic [255:0] line, input int unsigned ready_stall);
        int unsigned n;
        bit seen;
        logic [63:0] beat;
        seen = 1'b0;
        for (n = 0; n < 20 && !seen; n++) begin
            tick();
            if (bmem_read) seen = 1'b1;
        end
        chk("rd_req_seen", seen, 1);
        chk("rd_req_latency", n, 1);
        chk("rd_addr", bmem_addr, exp_addr);
        chk("rd_no_write", bmem_write, 0);
        repeat (ready_stall) begin
            tick();
            chk("rd_req_hold", bmem_read, 1);
        end
        bmem_ready = 1'b1;
        tick();
        bmem_ready = 1'b0;
        chk("rd_req_one_shot", bmem_read, 0);
        for (int k = 0; k < 4; k++) begin
            beat = line[k*64 +: 64];
            if (k == 2) begin
                bmem_rvalid = 1'b0;
                tick();
            end
            bmem_rvalid = 1'b1;
            bmem_rdata  = beat;
            tick();
        end
        bmem_rvalid = 1'b0;
        bmem_rdata  = '0;
        chk("rd_i_resp", i_resp, is_i);
        chk("rd_d_resp", d_resp, !is_i);
        chk("rd_line", is_i ? i_rdata : d_rdata, line);
        chk("rd_other_rdata", is_i ? d_rdata : i_rdata, 0);
        tick();
        if (is_i) i_read = 1'b0; else d_read = 1'b0;
        chk("rd_resp_pulse", {i_resp, d_resp}, 0);
    endtask

    task automatic serve_write(input logic [31:0] exp_addr, input logic [255:0] line,
                               input int unsigned stall_beat, input int unsigned stall_n);
        int unsigned n;
        bit seen;
        logic [63:0] beat;
        seen = 1'b0;
        for (n = 0; n < 20 && !seen; n++) begin
            tick();
            if (bmem_write) seen = 1'b1;
        end
        chk("wr_seen", seen, 1);
        chk("wr_latency", n, 1);
        chk("wr_addr", bmem_addr, exp_addr);
        chk("wr_no_read", bmem_read, 0);
        for (int k = 0; k < 4; k++) begin
            beat = line[k*64 +: 64];
            if (k == int'(stall_beat) && stall_n > 0) begin
                bmem_ready = 1'b0;
                repeat (stall_n) begin
                    tick();
                    chk("wr_stall_data", bmem_wdata, beat);
                    chk("wr_stall_valid", bmem_write, 1);
                end
            end
            chk("wr_beat", bmem_wdata, beat);
            chk("wr_no_resp_yet", d_resp, 0);
            bmem_ready = 1'b1;
            tick();
        end
        bmem_ready = 1'b0;
        chk("wr_d_resp", d_resp, 1);
        chk("wr_i_resp", i_resp, 0);
        chk("wr_no_extra_beat", bmem_write, 0);
        tick();
        d_write = 1'b0;
        chk("wr_resp_pulse", {i_resp, d_resp}, 0);
    endtask

    initial begin
        logic [255:0] la, lb;
        bit first_i;

        vecs[0] = '{1'b1, 1'b0, 32'h1000_0040, 32'h1000_0040,
                    {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                     64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}, 0, 0};
        vecs[1] = '{1'b0, 1'b0, 32'h3000_001C, 32'h3000_0000,
                    {64'hDEAD_BEEF_0000_0003, 64'hDEAD_BEEF_0000_0002,
                     64'hDEAD_BEEF_0000_0001, 64'hDEAD_BEEF_0000_0000}, 0, 2};
        vecs[2] = '{1'b0, 1'b1, 32'h2000_0020, 32'h2000_0020,
                    {64'hA3A3_A3A3_0000_0003, 64'hA2A2_A2A2_0000_0002,
                     64'hA1A1_A1A1_0000_0001, 64'hA0A0_A0A0_0000_0000}, 2, 3};
        vecs[3] = '{1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFE0,
                    {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                     64'h5555_AAAA_5555_AAAA, 64'h0F0F_F0F0_0F0F_F0F0}, 0, 1};
        vecs[4] = '{1'b0, 1'b1, 32'h0000_0000, 32'h0000_0000,
                    {64'h8000_0000_0000_0001, 64'h7000_0000_0000_0002,
                     64'h6000_0000_0000_0003, 64'h5000_0000_0000_0004}, 0, 0};

        rst = 1'b1;
        i_addr = '0; i_read = 1'b0;
        d_addr = '0; d_read = 1'b0; d_write = 1'b0; d_wdata = '0;
        bmem_ready = 1'b0; bmem_rdata = '0; bmem_rvalid = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("reset_outputs", {bmem_addr, bmem_read, bmem_write, bmem_wdata, i_resp, d_resp}, 0);
        chk("reset_rdata", i_rdata | d_rdata, 0);

        // Stray read beats while idle must not move the FSM.
        bmem_rvalid = 1'b1;
        bmem_rdata  = 64'hBAD0_BAD0_BAD0_BAD0;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("stray_idle", {bmem_read, bmem_write, i_resp, d_resp}, 0);
        end
        bmem_rvalid = 1'b0;
        bmem_rdata  = '0;
        tick();

        for (int v = 0; v < 5; v++) begin
            tick();
            if (vecs[v].is_i) begin
                i_addr = vecs[v].addr;
                d_addr = 32'h7777_7777;
                i_read = 1'b1;
                serve_read(1'b1, vecs[v].exp_addr, vecs[v].line, vecs[v].stall_n);
            end else if (vecs[v].wr) begin
                d_addr  = vecs[v].addr;
                i_addr  = 32'h6666_6666;
                d_wdata = vecs[v].line;
                d_write = 1'b1;
                serve_write(vecs[v].exp_addr, vecs[v].line, vecs[v].stall_beat, vecs[v].stall_n);
            end else begin
                d_addr = vecs[v].addr;
                i_addr = 32'h6666_6666;
                d_read = 1'b1;
                serve_read(1'b0, vecs[v].exp_addr, vecs[v].line, vecs[v].stall_n);
            end
        end

        // Simultaneous reads; the previous grant went to the D-cache.
`ifdef ARB_ROUND_ROBIN_EN
        first_i = 1'b1;
`else
        first_i = 1'b0;
`endif
        la = {64'hC3, 64'hC2, 64'hC1, 64'hC0};
        lb = {64'hD3, 64'hD2, 64'hD1, 64'hD0};
        tick();
        i_addr = 32'h4000_0100;
        d_addr = 32'h5000_0200;
        i_read = 1'b1;
        d_read = 1'b1;
        serve_read(first_i, first_i ? 32'h4000_0100 : 32'h5000_0200, la, 0);
        chk("tie_idle_gap", bmem_read, 0);
        serve_read(!first_i, first_i ? 32'h5000_0200 : 32'h4000_0100, lb, 0);

        // Reset after beat 1 of a read: no response, late beats discarded.
        tick();
        i_addr = 32'h1000_0080;
        i_read = 1'b1;
        for (int n = 0; n < 20 && !bmem_read; n++) tick();
        chk("rst_seq_req", bmem_read, 1);
        bmem_ready = 1'b1;
        tick();
        bmem_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            bmem_rvalid = 1'b1;
            bmem_rdata  = 64'hE0 + 64'(k);
            tick();
        end
        rst = 1'b1;
        i_read = 1'b0;
        bmem_rdata = 64'hE2;
        tick();
        rst = 1'b0;
        chk("rst_mid_idle", {bmem_read, bmem_write, i_resp, d_resp}, 0);
        bmem_rdata = 64'hE3;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("rst_late_beats", {bmem_read, bmem_write, i_resp, d_resp}, 0);
            bmem_rvalid = 1'b0;
        end
        d_addr = 32'h0800_0044;
        d_read = 1'b1;
        serve_read(1'b0, 32'h0800_0040, {64'hF3, 64'hF2, 64'hF1, 64'hF0}, 0);

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
